lcd_bus_writer: RTL and testbench

Downstream consumer of the 32-bit LCD command FIFO. Pops one word at a time and decodes it as an LCD command, a pixel/parameter write, or a timed delay. Drives the LCD's 16-bit 8080-style parallel write bus with programmable strobe timing. Generates the FIFO read strobe, which is wired to the FIFO's output clock; each rising edge of the strobe advances the FIFO by one word.

---
 rtl/lcd_bus_pkg.sv | 12 +
 rtl/lcd_delay_timer.sv | 32 +++
 rtl/lcd_bus_writer.sv | 94 +++++++++
 tb/tb_lcd_bus_writer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_pkg.sv
// lcd_bus_pkg: command-word field layout and state encoding for the LCD bus writer
package lcd_bus_pkg;
  localparam logic [1:0] TYPE_CMD   = 2'b00;
  localparam logic [1:0] TYPE_DATA  = 2'b01;
  localparam logic [1:0] TYPE_DELAY = 2'b10;
  localparam logic [1:0] TYPE_RSVD  = 2'b11;
  localparam int TYPE_MSB    = 31;
  localparam int TYPE_LSB    = 30;
  localparam int COUNT_MSB   = 23;
  localparam int PAYLOAD_MSB = 15;
  typedef enum logic [2:0] {IDLE, POP, SETUP, WR_LOW, WR_HIGH, DELAY, GAP} state_t;
endpackage

// File: rtl/lcd_delay_timer.sv
// lcd_delay_timer: prescaled 24-bit tick down-counter; done marks the final cycle of the delay
module lcd_delay_timer #(
  parameter int PRESCALE = 50
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        count,
  input  logic [23:0] ticks,
  output logic        done
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  logic [23:0]   left;
  logic [PW-1:0] pre;
  assign done = left == '0 || (left == 24'd1 && pre == '0);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      left <= '0;
      pre  <= '0;
    end else if (load) begin
      left <= ticks;
      pre  <= PMAX;
    end else if (count && left != '0) begin
      if (pre != '0) pre <= pre - 1'b1;
      else begin
        left <= left - 1'b1;
        pre  <= left == 24'd1 ? '0 : PMAX;
      end
    end
  end
endmodule

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: pops command-FIFO words and replays them as 8080-style LCD bus writes or timed delays
module lcd_bus_writer
  import lcd_bus_pkg::*;
#(
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2,
  parameter int DELAY_PRESCALE = 50
) (
  input  logic        i_clock,
  input  logic        i_resetN,
  input  logic        i_enable,
  input  logic [31:0] i_fifoData,
  input  logic        i_fifoEmpty,
  output logic        o_fifoReadStrobe,
  output logic [15:0] o_lcdData,
  output logic        o_lcdDcX,
  output logic        o_lcdWrN,
  output logic        o_lcdCsN,
  output logic        o_busy
);
  localparam int CMAX = WR_LOW_CYCLES > WR_HIGH_CYCLES ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
  localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] LOW_LAST  = CW'(WR_LOW_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(WR_HIGH_CYCLES - 1);
  state_t        state;
  logic [1:0]    kind;
  logic [23:0]   arg;
  logic [CW-1:0] cnt;
  logic          fetch, delay_done, unused_bits;
  assign fetch = i_enable && !i_fifoEmpty;
  assign o_busy = state != IDLE;
  assign unused_bits = ^i_fifoData[29:24];
  lcd_delay_timer #(.PRESCALE(DELAY_PRESCALE)) u_timer (
    .clock  (i_clock),
    .reset_n(i_resetN),
    .load   (state == POP && kind == TYPE_DELAY),
    .count  (state == DELAY),
    .ticks  (arg),
    .done   (delay_done)
  );
  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      state            <= IDLE;
      kind             <= TYPE_CMD;
      arg              <= '0;
      cnt              <= '0;
      o_fifoReadStrobe <= 1'b0;
      o_lcdData        <= '0;
      o_lcdDcX         <= 1'b1;
      o_lcdWrN         <= 1'b1;
      o_lcdCsN         <= 1'b1;
    end else begin
      o_fifoReadStrobe <= 1'b0;
      case (state)
        IDLE:
          if (fetch) begin
            state            <= POP;
            o_fifoReadStrobe <= 1'b1;
            kind             <= i_fifoData[TYPE_MSB:TYPE_LSB];
            arg              <= i_fifoData[COUNT_MSB:0];
          end else o_lcdCsN <= 1'b1;
        POP:
          if (kind == TYPE_CMD || kind == TYPE_DATA) begin
            state     <= SETUP;
            o_lcdData <= arg[PAYLOAD_MSB:0];
            o_lcdDcX  <= kind[0];
            o_lcdCsN  <= 1'b0;
          end else begin
            // zero-length delays and reserved words both take the one-cycle GAP path
            state    <= (kind == TYPE_DELAY && arg != '0) ? DELAY : GAP;
            o_lcdCsN <= 1'b1;
          end
        SETUP: begin
          state    <= WR_LOW;
          o_lcdWrN <= 1'b0;
          cnt      <= LOW_LAST;
        end
        WR_LOW:
          if (cnt == '0) begin
            state    <= WR_HIGH;
            o_lcdWrN <= 1'b1;
            cnt      <= HIGH_LAST;
          end else cnt <= cnt - 1'b1;
        WR_HIGH:
          if (cnt == '0) begin
            state    <= IDLE;
            o_lcdCsN <= !fetch;
          end else cnt <= cnt - 1'b1;
        DELAY: if (delay_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb_lcd_bus_writer: per-cycle schedule model of the LCD writer plus directed timing checks
module tb_lcd_bus_writer;
  localparam int WL = 2, WH = 2, PS = 50, LN = 4096;
  typedef struct packed {
    logic        stb;
    logic [15:0] data;
    logic        dcx;
    logic        wrn;
    logic        csn;
    logic        busy;
  } obs_t;
  localparam obs_t RST = '{stb: 1'b0, data: 16'h0, dcx: 1'b1, wrn: 1'b1, csn: 1'b1, busy: 1'b0};
  logic clk = 1'b0, rst_n, en, fifo_empty;
  logic [31:0] fifo_data;
  logic o_fifoReadStrobe, o_lcdDcX, o_lcdWrN, o_lcdCsN, o_busy;
  logic [15:0] o_lcdData;
  logic [31:0] fifo_q[$];
  obs_t sched[$];
  obs_t cur, log_o [LN];
  logic last_write;
  int cyc, n_vec, n_err;
  always #5 clk = ~clk;
  lcd_bus_writer #(.WR_LOW_CYCLES(WL), .WR_HIGH_CYCLES(WH), .DELAY_PRESCALE(PS)) dut (
    .i_clock(clk), .i_resetN(rst_n), .i_enable(en), .i_fifoData(fifo_data), .i_fifoEmpty(fifo_empty),
    .o_fifoReadStrobe(o_fifoReadStrobe), .o_lcdData(o_lcdData), .o_lcdDcX(o_lcdDcX),
    .o_lcdWrN(o_lcdWrN), .o_lcdCsN(o_lcdCsN), .o_busy(o_busy)
  );
  task automatic sync_fifo();
    fifo_empty = fifo_q.size() == 0;
    fifo_data  = fifo_empty ? 32'h0 : fifo_q[0];
  endtask
  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    sync_fifo();
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  // expand one fetched word into the expected outputs of every cycle from POP onward
  task automatic plan(input logic [31:0] w);
    obs_t c = cur;
    c.stb = 1'b1; c.busy = 1'b1; c.wrn = 1'b1;
    sched.push_back(c);
    c.stb = 1'b0;
    if (w[31] == 1'b0) begin
      c.csn = 1'b0; c.data = w[15:0]; c.dcx = w[30];
      sched.push_back(c);
      c.wrn = 1'b0;
      repeat (WL) sched.push_back(c);
      c.wrn = 1'b1;
      repeat (WH) sched.push_back(c);
      last_write = 1'b1;
    end else begin
      c.csn = 1'b1;
      repeat ((w[31:30] == 2'b10 && w[23:0] != 24'd0) ? int'(w[23:0]) * PS : 1) sched.push_back(c);
      last_write = 1'b0;
    end
  endtask
  task automatic model_loop();
    obs_t got;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sched.delete();
        cur = RST;
        last_write = 1'b0;
      end
      got = {o_fifoReadStrobe, o_lcdData, o_lcdDcX, o_lcdWrN, o_lcdCsN, o_busy};
      log_o[cyc % LN] = got;
      n_vec++;
      if (got !== cur) begin
        n_err++;
        $display("FAIL cycle %0d: got stb=%b data=%h dcx=%b wrn=%b csn=%b busy=%b, want stb=%b data=%h dcx=%b wrn=%b csn=%b busy=%b",
                 cyc, got.stb, got.data, got.dcx, got.wrn, got.csn, got.busy,
                 cur.stb, cur.data, cur.dcx, cur.wrn, cur.csn, cur.busy);
      end
      cyc++;
      if (rst_n) begin
        if (sched.size() != 0) cur = sched.pop_front();
        else if (cur.busy) begin
          cur.busy = 1'b0; cur.stb = 1'b0; cur.wrn = 1'b1;
          cur.csn = last_write ? !(en && fifo_q.size() != 0) : 1'b1;
        end else if (en && fifo_q.size() != 0) begin
          plan(fifo_q[0]);
          cur = sched.pop_front();
        end else cur.csn = 1'b1;
      end
    end
  endtask
  task automatic pop_loop();
    forever begin
      @(posedge o_fifoReadStrobe);
      if (fifo_q.size() != 0) fifo_q.delete(0);
      sync_fifo();
    end
  endtask
  function automatic obs_t at(input int c);
    return (c >= 0 && c < cyc) ? log_o[c % LN] : '1;
  endfunction
  function automatic int count(input int a, input int b, input int f);
    int n = 0;
    for (int c = a; c < b; c++) begin
      obs_t o = at(c);
      if ((f == 0 && o.stb) || (f == 1 && o.busy) || (f == 2 && !o.wrn) || (f == 3 && !o.csn)) n++;
    end
    return n;
  endfunction
  function automatic int nth_stb(input int from, input int n);
    int k = 0;
    for (int c = from; c < cyc; c++) begin
      obs_t o = at(c);
      if (o.stb) begin
        if (k == n) return c;
        k++;
      end
    end
    return -1;
  endfunction
  function automatic int nth_wr(input int from, input int n);
    int k = 0;
    for (int c = (from < 1 ? 1 : from); c < cyc; c++) begin
      obs_t o = at(c);
      obs_t p = at(c - 1);
      if (!o.wrn && p.wrn) begin
        if (k == n) return c;
        k++;
      end
    end
    return -1;
  endfunction
  function automatic int bus(input int c);
    obs_t o = at(c);
    return int'({o.dcx, o.data});
  endfunction
  function automatic logic [31:0] rand_word();
    int t = $urandom_range(0, 9);
    logic [31:0] w = $urandom;
    if (t < 4) w[31:30] = 2'b00;
    else if (t < 8) w[31:30] = 2'b01;
    else if (t == 8) begin
      w[31:30] = 2'b10;
      w[23:0] = 24'($urandom_range(0, 2));
    end else w[31:30] = 2'b11;
    return w;
  endfunction
  task automatic drain(input int budget);
    int k = 0;
    while ((fifo_q.size() != 0 || o_busy) && k < budget) begin
      step(1);
      k++;
    end
    chk("drain_timeout", (fifo_q.size() != 0 || o_busy) ? 1 : 0, 0);
    step(2);
  endtask
  initial begin
    int base, s0, s1, s2, w;
    logic seen;
    rst_n = 1'b0; en = 1'b0; cur = RST; last_write = 1'b0;
    cyc = 0; n_vec = 0; n_err = 0;
    sync_fifo();
    fork
      model_loop();
      pop_loop();
    join_none
    step(3);
    chk("rst_wrn", int'(o_lcdWrN), 1);
    chk("rst_csn", int'(o_lcdCsN), 1);
    chk("rst_dcx", int'(o_lcdDcX), 1);
    rst_n = 1'b1;
    // single command write
    en = 1'b1; step(1); base = cyc;
    push(32'h0000_002C); step(12);
    s0 = nth_stb(base, 0); w = nth_wr(base, 0);
    chk("cmd_strobes", count(base, cyc, 0), 1);
    chk("cmd_busy_cycles", count(base, cyc, 1), 6);
    chk("cmd_wrn_low_cycles", count(base, cyc, 2), 2);
    chk("cmd_bus", bus(w), 32'h0002C);
    chk("cmd_setup_bus", bus(s0 + 1), 32'h0002C);
    chk("cmd_csn_low_cycles", count(base, cyc, 3), 5);
    chk("cmd_csn_release", int'(at(s0 + 6).csn), 1);
    // pixel burst
    drain(100); base = cyc;
    push(32'h4000_F800); push(32'h4000_07E0); push(32'h4000_001F); step(26);
    s0 = nth_stb(base, 0); s1 = nth_stb(base, 1); s2 = nth_stb(base, 2);
    chk("burst_gap01", s1 - s0, 7);
    chk("burst_gap12", s2 - s1, 7);
    chk("burst_csn_held", count(s0 + 1, s2 + 6, 3), 19);
    chk("burst_csn_release", int'(at(s2 + 6).csn), 1);
    chk("burst_px0", bus(nth_wr(base, 0)), 32'h1F800);
    chk("burst_px1", bus(nth_wr(base, 1)), 32'h107E0);
    chk("burst_px2", bus(nth_wr(base, 2)), 32'h1001F);
    // timed delay followed by a command
    drain(100); base = cyc;
    push(32'h8000_0003); push(32'h0000_002A); step(170);
    s0 = nth_stb(base, 0); s1 = nth_stb(base, 1);
    chk("delay_fetch_gap", s1 - s0, 152);
    chk("delay_busy_cycles", count(s0 + 1, s0 + 151, 1), 150);
    chk("delay_wrn_low", count(s0, s1, 2), 0);
    chk("delay_csn_low", count(s0, s1, 3), 0);
    chk("delay_next_bus", bus(nth_wr(s1, 0)), 32'h0002A);
    // reserved word is dropped
    drain(300); base = cyc;
    push(32'hC000_1234); push(32'h0000_0011); step(16);
    s0 = nth_stb(base, 0); s1 = nth_stb(base, 1);
    chk("rsvd_fetch_gap", s1 - s0, 3);
    chk("rsvd_wrn_low", count(s0, s1 + 1, 2), 0);
    chk("rsvd_csn_low", count(s0, s1 + 1, 3), 0);
    chk("rsvd_next_bus", bus(nth_wr(s0, 0)), 32'h00011);
    chk("rsvd_single_write", nth_wr(s0, 1), -1);
    // enable gating
    drain(100); en = 1'b0; base = cyc;
    push(32'h0000_0033); step(6);
    chk("en_off_strobes", count(base, cyc, 0), 0);
    chk("en_off_busy", count(base, cyc, 1), 0);
    base = cyc; en = 1'b1; step(10);
    chk("en_on_latency", nth_stb(base, 0) - base, 1);
    // reset in the middle of a write
    drain(100);
    push(32'h0000_0055);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = !o_lcdWrN;
    end
    chk("rst_wr_low_reached", int'(seen), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_wrn", int'(o_lcdWrN), 1);
    chk("arst_csn", int'(o_lcdCsN), 1);
    chk("arst_strobe", int'(o_fifoReadStrobe), 0);
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_data", int'(o_lcdData), 0);
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    base = cyc; step(6);
    chk("post_rst_idle_busy", count(base, cyc, 1), 0);
    chk("post_rst_idle_strobe", count(base, cyc, 0), 0);
    // randomized traffic against the schedule model
    for (int i = 0; i < 150; i++) begin
      step($urandom_range(0, 5));
      repeat ($urandom_range(1, 3)) push(rand_word());
      if ($urandom_range(0, 4) == 0) en = ~en;
    end
    en = 1'b1;
    drain(20000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
